opb_register_bank_ppc2simulink: RTL and testbench

- Parametrised successor to the single-word PPC-to-Simulink OPB register.
- Provides C_NUM_REGS software-writable 32-bit channels with shadow/active double buffering, byte-enable writes, readback and an atomic commit.
- Each channel has a per-channel one-cycle load strobe for the user fabric, for example to load a set of filter centers in one step.
- Sits on the OPB as a slave. User logic runs on the same clock, so there is no clock-domain crossing.

---
 rtl/opb_register_bank_ppc2simulink_if.sv | 27 ++
 rtl/opb_register_bank_ppc2simulink.sv | 201 ++++++++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for opb_register_bank_ppc2simulink.
// Bit 0 is the MSB on every OPB vector (big-endian numbering).
//   master : drives address/data/control, receives Sl_* responses
//   slave  : receives address/data/control, drives Sl_* responses
interface opb_register_bank_ppc2simulink_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of C_NUM_REGS software-writable 32-bit channels on the OPB, each with a
// shadow (bus side) and an active (user side) copy. A COMMIT write copies all
// shadows to actives at once; in AUTO mode a shadow write also updates its
// active copy directly. Register map (word index from C_BASEADDR):
//   0..N-1 shadow channels, N CTRL (bit0 COMMIT w1, bit1 AUTO), N+1 STATUS.
// Ports:
//   OPB_Clk, OPB_Rst_n : clock, async active-low reset
//   bus                : OPB slave bundle
//   user_data_out      : active registers, channel k at [32k+31:32k]
//   user_load          : per-channel one-cycle strobe when active changes
//   commit_count       : number of commits since reset (wraps)
//
// state  | meaning
// IDLE   | waiting for a select that hits the window
// ACK    | single acknowledge cycle; writes take effect at its end
// HOLD   | waiting for select to drop so each select is acked once
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01180900,
    parameter logic [31:0] C_HIGHADDR   = 32'h011809FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [31:0] C_RESET_VAL  = 32'h00000000,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    opb_register_bank_ppc2simulink_if.slave bus,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_load,
    output logic [15:0]               commit_count
);

    if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_width_check
        $error("only 32-bit OPB address/data is supported");
    end
    if (C_NUM_REGS < 1 || C_NUM_REGS > 32) begin : g_num_check
        $error("C_NUM_REGS must be 1..32");
    end
    if ((C_HIGHADDR - C_BASEADDR + 32'd1) < 32'(4 * (C_NUM_REGS + 2))) begin : g_win_check
        $error("address window too small for the register map");
    end

    localparam logic [29:0] W_CTRL   = 30'(C_NUM_REGS);
    localparam logic [29:0] W_STATUS = 30'(C_NUM_REGS + 1);
    localparam bit unused_family = (C_FAMILY != "");

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [31:0]     shadow_q [C_NUM_REGS];
    logic [31:0]     shadow_d [C_NUM_REGS];
    logic [31:0]     active_q [C_NUM_REGS];
    logic [31:0]     active_d [C_NUM_REGS];
    logic            auto_q, auto_d;
    logic [15:0]     commit_cnt_q, commit_cnt_d;
    logic [C_NUM_REGS-1:0] load_q, load_d;
    logic [29:0]     widx_q, widx_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     addr;
    logic [31:0]     offset;
    logic [29:0]     widx;
    logic            hit;
    logic [31:0]     rd_mux;
    logic [31:0]     wdata;
    logic [3:0]      be;
    logic [31:0]     bmask;
    logic            wr_en;
    logic            ack;
    logic            unused_ok;

    // Vector assignment is positional, so OPB bit 0 lands on user bit 31 and
    // OPB_BE[0] lands on be[3] (user bits 31:24).
    assign addr   = bus.OPB_ABus;
    assign wdata  = bus.OPB_DBus;
    assign be     = bus.OPB_BE;
    assign hit    = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign offset = addr - C_BASEADDR;
    assign widx   = offset[31:2];

    always_comb begin
        bmask = '0;
        for (int b = 0; b < 4; b++) begin
            bmask[8*b +: 8] = {8{be[b]}};
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (widx == 30'(k)) begin
                rd_mux = shadow_q[k];
            end
        end
        if (widx == W_CTRL) begin
            rd_mux[1] = auto_q;
        end
        if (widx == W_STATUS) begin
            rd_mux[15:0] = commit_cnt_q;
        end
    end

    // Bus FSM; read data and target word are captured when the select is taken.
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.OPB_select && hit) begin
                    state_d = S_ACK;
                    widx_d  = widx;
                    rdata_d = bus.OPB_RNW ? rd_mux : 32'h0;
                end
            end
            S_ACK: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!bus.OPB_select) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack   = (state_q == S_ACK);
    assign wr_en = ack && !bus.OPB_RNW;

    always_comb begin
        shadow_d     = shadow_q;
        active_d     = active_q;
        auto_d       = auto_q;
        commit_cnt_d = commit_cnt_q;
        load_d       = '0;
        if (wr_en) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                if (widx_q == 30'(k)) begin
                    shadow_d[k] = (shadow_q[k] & ~bmask) | (wdata & bmask);
                    if (auto_q) begin
                        active_d[k] = shadow_d[k];
                        load_d[k]   = 1'b1;
                    end
                end
            end
            // Commit copies the pre-write shadows; a new AUTO value only
            // matters for later writes.
            if (widx_q == W_CTRL && be[0]) begin
                auto_d = wdata[1];
                if (wdata[0]) begin
                    active_d     = shadow_q;
                    load_d       = '1;
                    commit_cnt_d = commit_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q      <= S_IDLE;
            widx_q       <= '0;
            rdata_q      <= '0;
            auto_q       <= 1'b0;
            commit_cnt_q <= '0;
            load_q       <= '0;
            for (int k = 0; k < C_NUM_REGS; k++) begin
                shadow_q[k] <= C_RESET_VAL;
                active_q[k] <= C_RESET_VAL;
            end
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            rdata_q      <= rdata_d;
            auto_q       <= auto_d;
            commit_cnt_q <= commit_cnt_d;
            load_q       <= load_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
        assign user_data_out[32*k +: 32] = active_q[k];
    end

    assign user_load      = load_q;
    assign commit_count   = commit_cnt_q;
    assign bus.Sl_xferAck = ack;
    assign bus.Sl_DBus    = ack ? rdata_q : 32'h0;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

    assign unused_ok = ^{bus.OPB_seqAddr, offset[1:0], unused_family};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
module tb_opb_register_bank_ppc2simulink;
    localparam logic [31:0] BASE = 32'h01180900;

    logic         clk;
    logic         rst_n;
    logic [127:0] user_data_out;
    logic [3:0]   user_load;
    logic [15:0]  commit_count;

    int errors = 0;
    int checks = 0;

    // transaction snapshot
    int           acks;
    logic [31:0]  rdata;
    logic [31:0]  idle_dbus;
    logic [127:0] ud_after;
    logic [3:0]   ul_ack;
    logic [3:0]   ul_after;
    logic [3:0]   ul_after2;
    logic [15:0]  cc_after;

    opb_register_bank_ppc2simulink_if bus ();

    opb_register_bank_ppc2simulink dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .bus           (bus.slave),
        .user_data_out (user_data_out),
        .user_load     (user_load),
        .commit_count  (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One OPB transfer: select held for six cycles, snapshots taken around the ack.
    task automatic xfer(input logic [31:0] addr, input logic rnw,
                        input logic [31:0] data, input logic [3:0] be);
        int ackpos;
        ackpos    = -10;
        acks      = 0;
        rdata     = 32'h0;
        idle_dbus = 32'h0;
        ud_after  = 'x;
        ul_ack    = 'x;
        ul_after  = 'x;
        ul_after2 = 'x;
        cc_after  = 'x;
        @(negedge clk);
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_DBus   = data;
        bus.OPB_BE     = be;
        bus.OPB_select = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.Sl_xferAck) begin
                acks++;
                rdata  = bus.Sl_DBus;
                ul_ack = user_load;
                ackpos = i;
            end else begin
                idle_dbus |= bus.Sl_DBus;
            end
            if (i == ackpos + 1) begin
                ud_after = user_data_out;
                ul_after = user_load;
                cc_after = commit_count;
            end
            if (i == ackpos + 2) ul_after2 = user_load;
        end
        bus.OPB_select = 1'b0;
        bus.OPB_RNW    = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.OPB_ABus    = '0;
        bus.OPB_BE      = '0;
        bus.OPB_DBus    = '0;
        bus.OPB_RNW     = 1'b1;
        bus.OPB_select  = 1'b0;
        bus.OPB_seqAddr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 128'(bus.Sl_xferAck), 128'h0);
        check("rst_dbus", 128'(bus.Sl_DBus), 128'h0);
        check("rst_ud", user_data_out, 128'h0);
        check("rst_ul", 128'(user_load), 128'h0);
        check("rst_cc", 128'(commit_count), 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset readback, one ack per select
        for (int w = 0; w < 4; w++) begin
            xfer(BASE + 32'(4*w), 1'b1, 32'h0, 4'hF);
            check("rd_rst_shadow", 128'(rdata), 128'h0);
            check("rd_rst_acks", 128'(acks), 128'd1);
        end
        xfer(BASE + 32'h14, 1'b1, 32'h0, 4'hF);
        check("rd_rst_status", 128'(rdata), 128'h0);
        check("rd_rst_status_acks", 128'(acks), 128'd1);

        // AUTO=0: shadow write does not reach the user side until commit
        xfer(BASE + 32'h04, 1'b0, 32'hDEADBEEF, 4'hF);
        check("w1_write_acks", 128'(acks), 128'd1);
        check("w1_write_dbus", 128'(rdata), 128'h0);
        check("w1_active_unchanged", ud_after[63:32], 128'h0);
        check("w1_no_load", 128'(ul_after), 128'h0);
        xfer(BASE + 32'h04, 1'b1, 32'h0, 4'hF);
        check("w1_readback", 128'(rdata), 128'hDEADBEEF);
        xfer(BASE + 32'h10, 1'b0, 32'h1, 4'hF);
        check("commit_ul_during_ack", 128'(ul_ack), 128'h0);
        check("commit_active", ud_after[63:32], 128'hDEADBEEF);
        check("commit_ul", 128'(ul_after), 128'hF);
        check("commit_ul_pulse", 128'(ul_after2), 128'h0);
        check("commit_cc", 128'(cc_after), 128'd1);
        xfer(BASE + 32'h14, 1'b1, 32'h0, 4'hF);
        check("status_1", 128'(rdata), 128'd1);
        xfer(BASE + 32'h10, 1'b1, 32'h0, 4'hF);
        check("ctrl_rd_0", 128'(rdata), 128'h0);

        // byte enables
        xfer(BASE + 32'h00, 1'b0, 32'h11223344, 4'b1111);
        xfer(BASE + 32'h00, 1'b0, 32'hAABBCCDD, 4'b0101);
        xfer(BASE + 32'h00, 1'b1, 32'h0, 4'hF);
        check("be_merge", 128'(rdata), 128'h11BB33DD);

        // AUTO=1
        xfer(BASE + 32'h10, 1'b0, 32'h2, 4'hF);
        check("auto_set_no_load", 128'(ul_after), 128'h0);
        xfer(BASE + 32'h10, 1'b1, 32'h0, 4'hF);
        check("ctrl_rd_auto", 128'(rdata), 128'h2);
        xfer(BASE + 32'h08, 1'b0, 32'h00000007, 4'hF);
        check("auto_active", ud_after[95:64], 128'h7);
        check("auto_w0_untouched", ud_after[31:0], 128'h0);
        check("auto_ul", 128'(ul_after), 128'h4);
        check("auto_ul_pulse", 128'(ul_after2), 128'h0);
        check("auto_cc_same", 128'(cc_after), 128'd1);

        // COMMIT with AUTO cleared in the same write
        xfer(BASE + 32'h10, 1'b0, 32'h1, 4'hF);
        check("commit2_w0", ud_after[31:0], 128'h11BB33DD);
        check("commit2_ul", 128'(ul_after), 128'hF);
        check("commit2_cc", 128'(cc_after), 128'd2);
        xfer(BASE + 32'h10, 1'b1, 32'h0, 4'hF);
        check("auto_cleared", 128'(rdata), 128'h0);
        xfer(BASE + 32'h04, 1'b0, 32'h12345678, 4'hF);
        check("noauto_active_kept", ud_after[63:32], 128'hDEADBEEF);
        check("noauto_no_load", 128'(ul_after), 128'h0);

        // CTRL ignores writes without the low byte enabled
        xfer(BASE + 32'h10, 1'b0, 32'h3, 4'b1110);
        check("ctrl_be_cc", 128'(cc_after), 128'd2);
        check("ctrl_be_ul", 128'(ul_after), 128'h0);
        xfer(BASE + 32'h10, 1'b1, 32'h0, 4'hF);
        check("ctrl_be_auto", 128'(rdata), 128'h0);

        // STATUS is read-only
        xfer(BASE + 32'h14, 1'b0, 32'hFFFF, 4'hF);
        xfer(BASE + 32'h14, 1'b1, 32'h0, 4'hF);
        check("status_ro", 128'(rdata), 128'd2);

        // unmapped word inside the window, then outside the window
        xfer(32'h01180980, 1'b0, 32'hFFFFFFFF, 4'hF);
        check("hole_wr_acks", 128'(acks), 128'd1);
        xfer(32'h01180980, 1'b1, 32'h0, 4'hF);
        check("hole_acks", 128'(acks), 128'd1);
        check("hole_rd", 128'(rdata), 128'h0);
        xfer(32'h01180A00, 1'b1, 32'h0, 4'hF);
        check("miss_acks", 128'(acks), 128'd0);
        check("miss_dbus", 128'(idle_dbus), 128'h0);
        xfer(32'h011808FC, 1'b1, 32'h0, 4'hF);
        check("below_acks", 128'(acks), 128'd0);
        xfer(BASE + 32'hFC, 1'b1, 32'h0, 4'hF);
        check("top_word_acks", 128'(acks), 128'd1);

        // commit counter wrap
        @(negedge clk);
        force dut.commit_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.commit_cnt_q;
        xfer(BASE + 32'h14, 1'b1, 32'h0, 4'hF);
        check("status_ffff", 128'(rdata), 128'hFFFF);
        xfer(BASE + 32'h10, 1'b0, 32'h1, 4'hF);
        check("cc_wrap", 128'(cc_after), 128'h0);

        // reset during the ack cycle of a write
        @(negedge clk);
        bus.OPB_ABus   = BASE + 32'h0C;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_DBus   = 32'hCAFEF00D;
        bus.OPB_BE     = 4'hF;
        bus.OPB_select = 1'b1;
        @(negedge clk);
        check("rst_mid_ack_before", 128'(bus.Sl_xferAck), 128'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack_drop", 128'(bus.Sl_xferAck), 128'd0);
        check("rst_mid_dbus", 128'(bus.Sl_DBus), 128'h0);
        bus.OPB_select = 1'b0;
        bus.OPB_RNW    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ud", user_data_out, 128'h0);
        check("rst_mid_cc", 128'(commit_count), 128'h0);
        xfer(BASE + 32'h0C, 1'b1, 32'h0, 4'hF);
        check("rst_mid_w3", 128'(rdata), 128'h0);
        xfer(BASE + 32'h00, 1'b1, 32'h0, 4'hF);
        check("rst_mid_w0", 128'(rdata), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
